// File: rtl/counter_param_updown.sv
// Up/down modulo counter stepped by an internal tick divider, all on one clock.
// Define COUNTER_SATURATE_EN to hold at the count limits instead of wrapping.
module counter_param_updown #(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 16,
    parameter int DIV_COUNT = 50000000,
    parameter int DIV_WIDTH = 26
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] counter,
    output logic             tick,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0]     MAX_VAL  = WIDTH'(MODULUS - 1);
    localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(DIV_COUNT - 1);

    logic [DIV_WIDTH-1:0] div;
    logic [WIDTH-1:0]     load_clamped;
    logic [WIDTH-1:0]     step_val;
    logic                 at_limit;

    // Out-of-range load values clamp to the top of the count range.
    always_comb begin
        load_clamped = load_val;
        if (33'(load_val) >= 33'(MODULUS)) begin
            load_clamped = MAX_VAL;
        end
    end

    always_comb begin
        at_limit = up_dn ? (counter == MAX_VAL) : (counter == '0);
    end

    assign tc = at_limit;

    always_comb begin
        step_val = counter;
        if (at_limit) begin
`ifdef COUNTER_SATURATE_EN
            step_val = counter;
`else
            step_val = up_dn ? '0 : MAX_VAL;
`endif
        end else if (up_dn) begin
            step_val = counter + WIDTH'(1);
        end else begin
            step_val = counter - WIDTH'(1);
        end
    end

    // Load restarts the divider so the next step lands a full period later.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            div  <= '0;
            tick <= 1'b0;
        end else if (load) begin
            div  <= '0;
            tick <= 1'b0;
        end else if (div == DIV_LAST) begin
            div  <= '0;
            tick <= 1'b1;
        end else begin
            div  <= div + DIV_WIDTH'(1);
            tick <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            counter <= '0;
            wrap    <= 1'b0;
        end else if (load) begin
            counter <= load_clamped;
            wrap    <= 1'b0;
        end else if (tick && en) begin
            counter <= step_val;
            wrap    <= at_limit;
        end else begin
            wrap    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_counter_param_updown.sv
// Bench for counter_param_updown: cycle model compared every cycle plus literal checkpoints.
// Covers the modulo build and, with COUNTER_SATURATE_EN defined, the saturating build.
module tb_counter_param_updown;

    logic       clk = 1'b0;
    logic       rstn;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] counter1, counter2;
    logic       tick1, tick2, tc1, tc2, wrap1, wrap2;

    int checks = 0;
    int errors = 0;
    int tick_pulses;

    typedef struct {
        int cnt;
        int c;
        bit tick;
        bit wrap;
    } mdl_t;

    mdl_t m1 = '{0, 0, 1'b0, 1'b0};
    mdl_t m2 = '{0, 0, 1'b0, 1'b0};

    counter_param_updown #(.WIDTH(4), .MODULUS(10), .DIV_COUNT(4), .DIV_WIDTH(3)) dut1 (
        .clk(clk), .rstn(rstn), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
        .counter(counter1), .tick(tick1), .tc(tc1), .wrap(wrap1)
    );

    counter_param_updown #(.WIDTH(4), .MODULUS(16), .DIV_COUNT(1), .DIV_WIDTH(1)) dut2 (
        .clk(clk), .rstn(rstn), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
        .counter(counter2), .tick(tick2), .tc(tc2), .wrap(wrap2)
    );

    always #5 clk = ~clk;

    // Next state from the counting rules: c counts edges since the divider last restarted.
    function automatic mdl_t modelNext(mdl_t s, int modv, int divc,
                                       bit m_en, bit m_up, bit m_load, int m_lv);
        mdl_t n;
        n = s;
        if (m_load) begin
            n.cnt  = (m_lv >= modv) ? modv - 1 : m_lv;
            n.c    = 0;
            n.tick = 1'b0;
            n.wrap = 1'b0;
            return n;
        end
        n.c    = s.c + 1;
        n.tick = (n.c % divc) == 0;
        n.wrap = 1'b0;
        if (s.tick && m_en) begin
            if (m_up && s.cnt == modv - 1) begin
                n.wrap = 1'b1;
`ifdef COUNTER_SATURATE_EN
                n.cnt  = s.cnt;
`else
                n.cnt  = 0;
`endif
            end else if (!m_up && s.cnt == 0) begin
                n.wrap = 1'b1;
`ifdef COUNTER_SATURATE_EN
                n.cnt  = s.cnt;
`else
                n.cnt  = modv - 1;
`endif
            end else begin
                n.cnt = m_up ? s.cnt + 1 : s.cnt - 1;
            end
        end
        return n;
    endfunction

    always @(posedge clk or posedge rstn) begin
        if (rstn) begin
            m1 = '{0, 0, 1'b0, 1'b0};
            m2 = '{0, 0, 1'b0, 1'b0};
        end else begin
            m1 = modelNext(m1, 10, 4, en, up_dn, load, int'(load_val));
            m2 = modelNext(m2, 16, 1, en, up_dn, load, int'(load_val));
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Every falling edge both DUTs must match the model, including during reset.
    always @(negedge clk) begin
        checkOutput("m1.counter", int'(counter1), m1.cnt);
        checkOutput("m1.tick", int'(tick1), int'(m1.tick));
        checkOutput("m1.wrap", int'(wrap1), int'(m1.wrap));
        checkOutput("m1.tc", int'(tc1), int'(up_dn ? m1.cnt == 9 : m1.cnt == 0));
        checkOutput("m2.counter", int'(counter2), m2.cnt);
        checkOutput("m2.tick", int'(tick2), int'(m2.tick));
        checkOutput("m2.wrap", int'(wrap2), int'(m2.wrap));
        checkOutput("m2.tc", int'(tc2), int'(up_dn ? m2.cnt == 15 : m2.cnt == 0));
    end

    task automatic applyStimulus(input bit s_en, input bit s_up, input bit s_load, input int s_lv);
        en       = s_en;
        up_dn    = s_up;
        load     = s_load;
        load_val = 4'(s_lv);
    endtask

    task automatic waitEdges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b1;
        applyStimulus(1, 1, 0, 0);
        waitEdges(3);
        rstn = 1'b0;

        // Up count: value k appears after edge 4k+1
        waitEdges(37);
        checkOutput("up.at9", int'(counter1), 9);
        checkOutput("up.tc9", int'(tc1), 1);
        waitEdges(4);
        checkOutput("up.wrap0", int'(counter1), 0);
        checkOutput("up.wrapPulse", int'(wrap1), 1);
        waitEdges(1);
        checkOutput("up.wrapOnce", int'(wrap1), 0);

        // Down count from a loaded 2
        applyStimulus(1, 0, 1, 2);
        waitEdges(1);
        checkOutput("dn.load2", int'(counter1), 2);
        checkOutput("dn.loadTick", int'(tick1), 0);
        applyStimulus(1, 0, 0, 2);
        waitEdges(5);
        checkOutput("dn.at1", int'(counter1), 1);
        waitEdges(4);
        checkOutput("dn.at0", int'(counter1), 0);
        checkOutput("dn.tc0", int'(tc1), 1);
        waitEdges(4);
        checkOutput("dn.wrap9", int'(counter1), 9);
        checkOutput("dn.wrapPulse", int'(wrap1), 1);

        // Clamped load on a tick cycle beats the step and restarts the divider
        waitEdges(3);
        checkOutput("ld.tickHigh", int'(tick1), 1);
        applyStimulus(1, 0, 1, 12);
        waitEdges(1);
        checkOutput("ld.clamp", int'(counter1), 9);
        checkOutput("ld.noWrap", int'(wrap1), 0);
        checkOutput("ld.tickCleared", int'(tick1), 0);
        applyStimulus(1, 0, 0, 12);
        waitEdges(3);
        checkOutput("ld.tickWait", int'(tick1), 0);
        waitEdges(1);
        checkOutput("ld.tickAgain", int'(tick1), 1);

        // Enable gating: divider keeps running
        applyStimulus(0, 0, 0, 12);
        tick_pulses = 0;
        for (int i = 0; i < 12; i++) begin
            waitEdges(1);
            tick_pulses += int'(tick1);
        end
        checkOutput("en.tickCount", tick_pulses, 3);
        checkOutput("en.hold", int'(counter1), 9);
        applyStimulus(1, 1, 0, 12);
        waitEdges(1);
`ifdef COUNTER_SATURATE_EN
        checkOutput("sat.hold1", int'(counter1), 9);
`else
        checkOutput("en.resume", int'(counter1), 0);
`endif
        checkOutput("en.limitPulse", int'(wrap1), 1);
        waitEdges(1);
        checkOutput("en.pulseOnce", int'(wrap1), 0);
        waitEdges(3);
`ifdef COUNTER_SATURATE_EN
        checkOutput("sat.hold2", int'(counter1), 9);
        checkOutput("sat.pulse2", int'(wrap1), 1);
`else
        checkOutput("en.step1", int'(counter1), 1);
        checkOutput("en.noWrap", int'(wrap1), 0);
`endif

        // Full-range modulus with a tick every cycle
        applyStimulus(1, 1, 1, 15);
        waitEdges(1);
        checkOutput("full.load15", int'(counter2), 15);
        applyStimulus(1, 1, 0, 15);
        waitEdges(1);
        checkOutput("full.tick", int'(tick2), 1);
        waitEdges(1);
`ifdef COUNTER_SATURATE_EN
        checkOutput("full.sat15", int'(counter2), 15);
`else
        checkOutput("full.wrap0", int'(counter2), 0);
`endif
        checkOutput("full.wrapPulse", int'(wrap2), 1);

        // Asynchronous reset mid-count, then first tick on the 4th edge
        rstn = 1'b1;
        #1;
        checkOutput("rst.counter", int'(counter1), 0);
        checkOutput("rst.tick2", int'(tick2), 0);
        checkOutput("rst.wrap", int'(wrap2), 0);
        waitEdges(2);
        rstn = 1'b0;
        waitEdges(3);
        checkOutput("rst.noTickYet", int'(tick1), 0);
        waitEdges(1);
        checkOutput("rst.firstTick", int'(tick1), 1);

        waitEdges(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
